// File: rtl/seq_shifter32_if.sv
// Request/response bundle for the sequential shifter: operand, control and
// start on the way in; busy/done/result on the way out.
interface seq_shifter32_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   shamt;
    logic             lr;
    logic             al;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (
        output start, din, shamt, lr, al,
        input  busy, done, dout
    );

    modport slave (
        input  start, din, shamt, lr, al,
        output busy, done, dout
    );
endinterface

// File: rtl/seq_shifter32.sv
// One-bit-per-clock shifter (left, logical right, arithmetic right) with a
// start/busy/done handshake; result latency is max(shamt,1) cycles.
module seq_shifter32 #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    seq_shifter32_if.slave     bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_reg,  state_next;
    logic [WIDTH-1:0] sreg_reg,   sreg_next;
    logic [SHW-1:0]   cnt_reg,    cnt_next;
    logic             lr_reg,     lr_next;
    logic             al_reg,     al_next;
    logic [WIDTH-1:0] dout_reg,   dout_next;

    logic [WIDTH-1:0] sreg_shifted;
    logic [WIDTH-1:0] din_shifted;

    function automatic logic [WIDTH-1:0] shift1(
        input logic [WIDTH-1:0] v,
        input logic             left,
        input logic             arith
    );
        if (left)
            return {v[WIDTH-2:0], 1'b0};
        else
            return {arith & v[WIDTH-1], v[WIDTH-1:1]};
    endfunction

    assign sreg_shifted = shift1(sreg_reg, lr_reg, al_reg);
    // The first shift is folded into the accept cycle so that done lands
    // exactly shamt cycles after start.
    assign din_shifted  = shift1(bus.din, bus.lr, bus.al);

    always_comb begin
        state_next = state_reg;
        sreg_next  = sreg_reg;
        cnt_next   = cnt_reg;
        lr_next    = lr_reg;
        al_next    = al_reg;
        dout_next  = dout_reg;
        case (state_reg)
            ST_SHIFT: begin
                sreg_next = sreg_shifted;
                cnt_next  = cnt_reg - SHW'(1);
                if (cnt_reg == SHW'(1)) begin
                    state_next = ST_DONE;
                    dout_next  = sreg_shifted;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request
                state_next = ST_IDLE;
                if (bus.start) begin
                    lr_next = bus.lr;
                    al_next = bus.al;
                    if (bus.shamt == '0) begin
                        sreg_next  = bus.din;
                        cnt_next   = '0;
                        dout_next  = bus.din;
                        state_next = ST_DONE;
                    end else if (bus.shamt == SHW'(1)) begin
                        sreg_next  = din_shifted;
                        cnt_next   = '0;
                        dout_next  = din_shifted;
                        state_next = ST_DONE;
                    end else begin
                        sreg_next  = din_shifted;
                        cnt_next   = bus.shamt - SHW'(1);
                        state_next = ST_SHIFT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sreg_reg  <= '0;
            cnt_reg   <= '0;
            lr_reg    <= 1'b0;
            al_reg    <= 1'b0;
            dout_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sreg_reg  <= sreg_next;
            cnt_reg   <= cnt_next;
            lr_reg    <= lr_next;
            al_reg    <= al_next;
            dout_reg  <= dout_next;
        end
    end

    assign bus.busy = (state_reg == ST_SHIFT);
    assign bus.done = (state_reg == ST_DONE);
    assign bus.dout = dout_reg;
endmodule

// File: tb/tb_seq_shifter32.sv
// Self-checking bench for seq_shifter32: directed cases plus randomized
// operations compared against a shift-operator reference model.
module tb_seq_shifter32;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    seq_shifter32_if #(.WIDTH(32), .SHW(5)) bus ();

    seq_shifter32 #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s,
                                              input logic l, input logic a);
        if (l)
            return d << s;
        else if (a)
            return 32'($signed(d) >>> s);
        else
            return d >> s;
    endfunction

    // Issues one op and waits for done; leaves time at the negedge of the done
    // cycle so the caller may issue the next op back to back.
    task automatic issue_wait(input logic [31:0] d, input logic [4:0] s, input logic l,
                              input logic a, output int lat, output int bc,
                              output logic [31:0] res);
        bus.din = d; bus.shamt = s; bus.lr = l; bus.al = a; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.din = $urandom; bus.shamt = 5'($urandom); bus.lr = 1'($urandom); bus.al = 1'($urandom);
        lat = -1; bc = 0; res = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k; res = bus.dout;
                break;
            end
            if (bus.busy) bc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.din = '0; bus.shamt = '0; bus.lr = 1'b0; bus.al = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_checks++;
        if (bus.dout !== 32'h0) begin n_errors++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
        $display("reset: busy=%b done=%b dout=%h", bus.busy, bus.done, bus.dout);
    endtask

    task automatic test_directed(input string name, input logic [31:0] d, input logic [4:0] s,
                                 input logic l, input logic a, input logic [31:0] exp_res,
                                 input int exp_lat, input int exp_bc);
        int lat, bc;
        logic [31:0] res;
        issue_wait(d, s, l, a, lat, bc, res);
        $display("%s: din=%h shamt=%0d lr=%b al=%b -> dout=%h lat=%0d busy_cycles=%0d",
                 name, d, s, l, a, res, lat, bc);
        n_checks++;
        if (res !== exp_res) begin n_errors++; $display("FAIL %s_dout: got %h want %h", name, res, exp_res); end
        n_checks++;
        if (lat != exp_lat) begin n_errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
        n_checks++;
        if (bc != exp_bc) begin n_errors++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, bc, exp_bc); end
    endtask

    task automatic test_back_to_back();
        int lat_a, lat_b;
        logic [31:0] res_a, res_b;
        bus.din = 32'h1; bus.shamt = 5'd3; bus.lr = 1'b1; bus.al = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat_a = -1; res_a = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin lat_a = k; res_a = bus.dout; break; end
            // ignored requests while busy
            bus.din = 32'hFFFF_0000 | 32'(k); bus.shamt = 5'd0; bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        $display("b2b A: dout=%h lat=%0d", res_a, lat_a);
        n_checks++;
        if (res_a !== 32'h8) begin n_errors++; $display("FAIL b2b_a_dout: got %h want 00000008", res_a); end
        n_checks++;
        if (lat_a != 3) begin n_errors++; $display("FAIL b2b_a_latency: got %0d want 3", lat_a); end
        begin
            int bc;
            issue_wait(32'hF000_0000, 5'd2, 1'b0, 1'b1, lat_b, bc, res_b);
        end
        $display("b2b B: dout=%h lat=%0d", res_b, lat_b);
        n_checks++;
        if (res_b !== 32'hFC00_0000) begin n_errors++; $display("FAIL b2b_b_dout: got %h want fc000000", res_b); end
        n_checks++;
        if (lat_b != 2) begin n_errors++; $display("FAIL b2b_b_latency: got %0d want 2", lat_b); end
    endtask

    task automatic test_reset_mid();
        int saw_done;
        @(posedge clk); #1;
        bus.din = 32'h1234_5678; bus.shamt = 5'd20; bus.lr = 1'b1; bus.al = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        $display("reset_mid: busy=%b done=%b dout=%h", bus.busy, bus.done, bus.dout);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        n_checks++;
        if (bus.done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done: got %b want 0", bus.done); end
        n_checks++;
        if (bus.dout !== 32'h0) begin n_errors++; $display("FAIL rstmid_dout: got %h want 0", bus.dout); end
        saw_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.busy) saw_done++;
        end
        n_checks++;
        if (saw_done != 0) begin n_errors++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", saw_done); end
    endtask

    task automatic test_random();
        int lat, bc, s, exp_lat;
        logic [31:0] d, res, exp_res;
        logic l, a;
        for (int i = 0; i < 40; i++) begin
            d = $urandom; s = $urandom_range(0, 31); l = 1'($urandom); a = 1'($urandom);
            if (i < 4) s = (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 2 : 31;
            exp_res = ref_shift(d, s, l, a);
            exp_lat = (s == 0) ? 1 : s;
            issue_wait(d, 5'(s), l, a, lat, bc, res);
            $display("rand %0d: din=%h shamt=%0d lr=%b al=%b -> dout=%h lat=%0d", i, d, s, l, a, res, lat);
            n_checks++;
            if (res !== exp_res) begin n_errors++; $display("FAIL rand_dout: got %h want %h", res, exp_res); end
            n_checks++;
            if (lat != exp_lat) begin n_errors++; $display("FAIL rand_latency: got %0d want %0d", lat, exp_lat); end
            n_checks++;
            if (bc != exp_lat - 1) begin n_errors++; $display("FAIL rand_busy_cycles: got %0d want %0d", bc, exp_lat - 1); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_directed("left4",  32'h0000_00F0, 5'd4,  1'b1, 1'b0, 32'h0000_0F00, 4,  3);
        test_directed("sra31",  32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF, 31, 30);
        test_directed("srl31",  32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001, 31, 30);
        test_directed("zero",   32'hDEAD_BEEF, 5'd0,  1'b0, 1'b1, 32'hDEAD_BEEF, 1,  0);
        test_directed("sll_al", 32'h8000_0003, 5'd1,  1'b1, 1'b1, 32'h0000_0006, 1,  0);
        @(posedge clk); #1;
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
